frame_read_requester: RTL and testbench

//  Peripheral client of the memory arbiter. On start it streams one frame
//  (LINES x LINE_LENGTH words from BASE_ADDRESS) out of RAM via read requests,

---
 rtl/frame_read_requester.sv | 115 +++++++++++
 tb/tb_frame_read_requester.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_requester.sv
// Streams one frame out of RAM through the arbiter port as credit-limited read
// requests and replays the in-order returns as a valid/ready pixel stream.
module frame_read_requester #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 16,
  parameter int BASE_ADDRESS  = 0,
  parameter int LINE_LENGTH   = 64,
  parameter int LINES         = 32,
  parameter int BUFFER_DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_wr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     mem_data_in_ready,
  input  logic                     mem_fifo_full,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_data_out_ready,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     line_end,
  output logic                     frame_end,
  output logic                     error
);
  localparam int TOTAL = LINE_LENGTH * LINES;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int FA    = $clog2(BUFFER_DEPTH);
  localparam int PW    = FA + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_LENGTH - 1);
  localparam logic [PW-1:0] DEPTH    = PW'(BUFFER_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [IW-1:0]         req_idx, pop_idx;
  logic [CW-1:0]         col;
  logic [PW-1:0]         credits, outstanding, ptr_w, ptr_r;
  logic [DATA_WIDTH-1:0] buf_mem [BUFFER_DEPTH];
  logic                  issue, pop, full, ret_live, ret_ok;

  assign issue     = (state == ISSUE) && !mem_fifo_full && (credits != '0);
  assign full      = (ptr_w ^ ptr_r) == {1'b1, {FA{1'b0}}};
  assign pix_valid = (ptr_w != ptr_r);
  assign pop       = pix_valid && pix_ready;
  // A full FIFO may still take a word when the head pops in the same cycle.
  assign ret_live  = mem_data_out_ready && (outstanding != '0);
  assign ret_ok    = ret_live && (!full || pop);

  assign mem_wr            = 1'b0;
  assign mem_data_in       = '0;
  assign mem_data_in_ready = issue;
  assign mem_address       = (state == ISSUE) ?
                             ADDRESS_WIDTH'(BASE_ADDRESS) + ADDRESS_WIDTH'(req_idx) : '0;

  assign busy      = (state != IDLE);
  assign pix_data  = pix_valid ? buf_mem[ptr_r[FA-1:0]] : '0;
  assign line_end  = pix_valid && (col == LAST_COL);
  assign frame_end = pix_valid && (pop_idx == LAST_IDX);
  assign done      = pop && frame_end && (state == DRAIN);

  always_ff @(posedge clk) begin
    if (ret_ok) buf_mem[ptr_w[FA-1:0]] <= mem_data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_idx     <= '0;
      pop_idx     <= '0;
      col         <= '0;
      credits     <= DEPTH;
      outstanding <= '0;
      ptr_w       <= '0;
      ptr_r       <= '0;
      error       <= 1'b0;
    end else begin
      if (mem_data_out_ready && !ret_ok) error <= 1'b1;
      if (ret_ok) ptr_w <= ptr_w + PW'(1);
      if (pop) begin
        ptr_r   <= ptr_r + PW'(1);
        pop_idx <= pop_idx + IW'(1);
        col     <= (col == LAST_COL) ? '0 : col + CW'(1);
      end

      // Credits cover both in-flight requests and words parked in the FIFO.
      if (issue && !pop)      credits <= credits - PW'(1);
      else if (pop && !issue) credits <= credits + PW'(1);

      if (issue && !ret_live)      outstanding <= outstanding + PW'(1);
      else if (ret_live && !issue) outstanding <= outstanding - PW'(1);

      case (state)
        IDLE: if (start) begin
          state   <= ISSUE;
          req_idx <= '0;
          pop_idx <= '0;
          col     <= '0;
        end
        ISSUE: if (issue) begin
          req_idx <= req_idx + IW'(1);
          if (req_idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_read_requester.sv
// Frame requester bench: 3-cycle in-order RAM model, request log and a pixel
// scoreboard; base address sits two words below the 25-bit wrap point.
module tb_frame_read_requester;
  localparam int AW = 25, DW = 16, LL = 4, LN = 2, BD = 4, N = LL * LN;
  localparam int BASE = (1 << 25) - 2;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, mem_fifo_full = 1'b0;
  logic          pix_ready = 1'b0, stray = 1'b0, ret_m = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          mem_ret;
  logic          busy, done, mem_wr, mem_data_in_ready, pix_valid, line_end, frame_end, error;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, pix_data;

  assign mem_ret = ret_m | stray;
  always #5 clk = ~clk;

  frame_read_requester #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDRESS(BASE),
    .LINE_LENGTH(LL), .LINES(LN), .BUFFER_DEPTH(BD)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_wr(mem_wr), .mem_data_in(mem_data_in),
    .mem_data_in_ready(mem_data_in_ready), .mem_fifo_full(mem_fifo_full),
    .mem_data_out(rdata), .mem_data_out_ready(mem_ret),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .line_end(line_end), .frame_end(frame_end), .error(error)
  );

  typedef struct packed {logic [DW-1:0] d; logic le; logic fe; logic dn;} pix_t;
  typedef struct {logic [AW-1:0] a; int due;} pend_t;

  pend_t         pend[$];
  logic [AW-1:0] req_log[$];
  pix_t          obs_q[$];
  pix_t          exp_q[$];
  int ncyc = 0, done_cnt = 0, checks = 0, errors = 0;

  // RAM model and monitors: everything sampled on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (done) done_cnt++;
    if (pix_valid && pix_ready) obs_q.push_back('{pix_data, line_end, frame_end, done});
    if (rst) begin
      pend.delete();
      ret_m = 1'b0;
    end else begin
      if (mem_data_in_ready) begin
        pend.push_back('{mem_address, ncyc + 3});
        req_log.push_back(mem_address);
      end
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        ret_m = 1'b1;
        rdata = pend[0].a[DW-1:0];
        void'(pend.pop_front());
      end else ret_m = 1'b0;
    end
  end

  function automatic logic [AW-1:0] exp_addr(int i);
    return AW'(BASE + i);
  endfunction

  function automatic pix_t exp_pix(int i);
    pix_t p;
    logic [AW-1:0] a;
    a    = exp_addr(i);
    p.d  = a[DW-1:0];
    p.le = (i % LL) == LL - 1;
    p.fe = (i == N - 1);
    p.dn = p.fe;
    return p;
  endfunction

  task automatic step;
    @(negedge clk); #1;
  endtask

  task automatic drive_edge;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start;
    drive_edge; start = 1'b1;
    drive_edge; start = 1'b0;
  endtask

  task automatic push_frame;
    for (int i = 0; i < N; i++) exp_q.push_back(exp_pix(i));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) step;
    checks++;
    if ({busy, done, mem_data_in_ready, pix_valid, line_end, frame_end, error, mem_wr} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {busy, done, mem_data_in_ready, pix_valid, line_end, frame_end, error, mem_wr});
    end
    checks++;
    if (mem_address !== '0 || pix_data !== '0 || mem_data_in !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h pix=%h wdata=%h want 0", mem_address, pix_data, mem_data_in);
    end
    drive_edge; rst = 1'b0;
  endtask

  task automatic test_frame;
    int r0, o0, d0;
    r0 = req_log.size(); o0 = obs_q.size(); d0 = done_cnt;
    push_frame;
    drive_edge; pix_ready = 1'b1;
    pulse_start;
    step;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %b want 1", busy); end
    for (int c = 0; c < 300 && done_cnt == d0; c++) step;
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL frame_done got %0d want %0d", done_cnt - d0, 1); end
    step;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_fall got %b want 0", busy); end
    checks++;
    if (req_log.size() - r0 != N) begin errors++; $display("FAIL frame_req_count got %0d want %0d", req_log.size() - r0, N); end
    for (int i = 0; i < N && r0 + i < req_log.size(); i++) begin
      checks++;
      if (req_log[r0 + i] !== exp_addr(i)) begin
        errors++; $display("FAIL frame_addr[%0d] got %h want %h", i, req_log[r0 + i], exp_addr(i));
      end
    end
    for (int i = o0; i < obs_q.size(); i++) begin
      pix_t e;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL frame_pix extra word %h", obs_q[i]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[i] !== e) begin errors++; $display("FAIL frame_pix[%0d] got %h want %h", i - o0, obs_q[i], e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL frame_pix_missing got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL frame_error got %b want 0", error); end
  endtask

  task automatic test_backpressure;
    int r0, o0, d0;
    r0 = req_log.size(); o0 = obs_q.size(); d0 = done_cnt;
    push_frame;
    drive_edge; pix_ready = 1'b0;
    pulse_start;
    repeat (20) step;
    checks++;
    if (req_log.size() - r0 != BD) begin errors++; $display("FAIL bp_stall_count got %0d want %0d", req_log.size() - r0, BD); end
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== exp_pix(0).d) begin
      errors++; $display("FAIL bp_head got v=%b d=%h want v=1 d=%h", pix_valid, pix_data, exp_pix(0).d);
    end
    drive_edge; pix_ready = 1'b1;
    drive_edge; pix_ready = 1'b0;
    repeat (8) step;
    checks++;
    if (req_log.size() - r0 != BD + 1) begin errors++; $display("FAIL bp_one_per_pop got %0d want %0d", req_log.size() - r0, BD + 1); end
    drive_edge; pix_ready = 1'b1;
    for (int c = 0; c < 300 && done_cnt == d0; c++) step;
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt - d0); end
    for (int i = o0; i < obs_q.size(); i++) begin
      pix_t e;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_pix extra word %h", obs_q[i]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[i] !== e) begin errors++; $display("FAIL bp_pix[%0d] got %h want %h", i - o0, obs_q[i], e); end
      end
    end
    checks++;
    if (exp_q.size() != 0 || error !== 1'b0) begin
      errors++; $display("FAIL bp_end got left=%0d err=%b want 0 0", exp_q.size(), error);
    end
    exp_q.delete();
  endtask

  task automatic test_fifo_full;
    int r0, o0, d0, n0;
    r0 = req_log.size(); o0 = obs_q.size(); d0 = done_cnt;
    push_frame;
    pulse_start;
    for (int c = 0; c < 50 && req_log.size() - r0 < 2; c++) step;
    drive_edge; mem_fifo_full = 1'b1;
    n0 = req_log.size();
    repeat (10) @(posedge clk);
    #1 mem_fifo_full = 1'b0;
    checks++;
    if (req_log.size() != n0) begin errors++; $display("FAIL full_hold got %0d strobes want 0", req_log.size() - n0); end
    for (int c = 0; c < 300 && done_cnt == d0; c++) step;
    checks++;
    if (req_log.size() - r0 != N) begin errors++; $display("FAIL full_req_count got %0d want %0d", req_log.size() - r0, N); end
    for (int i = 0; i < N && r0 + i < req_log.size(); i++) begin
      checks++;
      if (req_log[r0 + i] !== exp_addr(i)) begin
        errors++; $display("FAIL full_addr[%0d] got %h want %h", i, req_log[r0 + i], exp_addr(i));
      end
    end
    for (int i = o0; i < obs_q.size(); i++) begin
      pix_t e;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL full_pix extra word %h", obs_q[i]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[i] !== e) begin errors++; $display("FAIL full_pix[%0d] got %h want %h", i - o0, obs_q[i], e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL full_pix_missing got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_start_busy;
    int r0, o0, d0;
    r0 = req_log.size(); o0 = obs_q.size(); d0 = done_cnt;
    push_frame;
    pulse_start;
    repeat (3) step;
    pulse_start;
    for (int c = 0; c < 100 && req_log.size() - r0 < N; c++) step;
    pulse_start;
    for (int c = 0; c < 300 && done_cnt == d0; c++) step;
    repeat (10) step;
    checks++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start got done=%0d busy=%b want done=1 busy=0", done_cnt - d0, busy);
    end
    checks++;
    if (req_log.size() - r0 != N) begin errors++; $display("FAIL busy_req_count got %0d want %0d", req_log.size() - r0, N); end
    for (int i = o0; i < obs_q.size(); i++) begin
      pix_t e;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL busy_pix extra word %h", obs_q[i]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[i] !== e) begin errors++; $display("FAIL busy_pix[%0d] got %h want %h", i - o0, obs_q[i], e); end
      end
    end
    exp_q.delete();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL stray_pre got %b want 0", error); end
    drive_edge; stray = 1'b1;
    drive_edge; stray = 1'b0;
    repeat (3) step;
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL stray_error got %b want 1", error); end
  endtask

  task automatic test_reset_mid;
    int r0;
    r0 = req_log.size();
    pulse_start;
    for (int c = 0; c < 100 && req_log.size() - r0 < N; c++) step;
    drive_edge;
    checks++;
    if (busy !== 1'b1 || mem_data_in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_drain got busy=%b req=%b want 1 0", busy, mem_data_in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_data_in_ready, pix_valid, line_end, frame_end, error} !== 7'b0) begin
      errors++; $display("FAIL mid_reset got %b want 0000000",
                         {busy, done, mem_data_in_ready, pix_valid, line_end, frame_end, error});
    end
    drive_edge; rst = 1'b0;
    repeat (2) step;
    test_frame;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_frame;
    test_backpressure;
    test_fifo_full;
    test_start_busy;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
